// File: rtl/grade_pkg.sv
// grade_pkg: shared constants, FSM state and record type for the grade accumulator
package grade_pkg;
    localparam int SCORE_MIN     = 0;
    localparam int SCORE_MAX     = 100;
    localparam int INVALID_VALUE = -1;
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} acc_state_t;
    typedef struct packed {
        logic signed [7:0] base;
        logic              extra;
        logic signed [7:0] bonus;
        logic [7:0]        id;
    } grade_record_t;
endpackage

// File: rtl/grade_bonus_saturator.sv
// grade_bonus_saturator: saturating bonus register with clear, load and sticky bad flag
//   clr_i clears, load_i adds value_i (negative sets bad), nxt_*_o expose next-state values
module grade_bonus_saturator import grade_pkg::*; #(
    parameter int SCORE_W   = 8,
    parameter int MAX_BONUS = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      load_i,
    input  logic signed [SCORE_W-1:0] value_i,
    output logic        [SCORE_W-1:0] nxt_bonus_o,
    output logic                      nxt_bad_o
);
    localparam logic [SCORE_W:0] MAX_W = (SCORE_W + 1)'(MAX_BONUS);
    logic [SCORE_W-1:0] bonus_q, bonus_d;
    logic               bad_q, bad_d;
    logic [SCORE_W:0]   sum;
    logic               neg;
    always_comb begin
        neg     = value_i[SCORE_W-1];
        sum     = {1'b0, bonus_q} + {1'b0, value_i};
        bonus_d = clr_i ? '0 : (load_i && !neg) ? ((sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0]) : bonus_q;
        bad_d   = clr_i ? 1'b0 : bad_q | (load_i & neg);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bonus_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            bonus_q <= bonus_d;
            bad_q   <= bad_d;
        end
    end
    assign nxt_bonus_o = bonus_d;
    assign nxt_bad_o   = bad_d;
endmodule

// File: rtl/grade_score_accumulator.sv
// grade_score_accumulator: collects NUM_SCORES scores plus bonuses into one evaluator record
//   score_*/bonus_* : input handshakes, flush drops a partial record
//   rec_*           : record handshake and fields, rec_count is a debug score count
module grade_score_accumulator import grade_pkg::*; #(
    parameter int NUM_SCORES = 4,
    parameter int SCORE_W    = 8,
    parameter int MAX_BONUS  = 20,
    parameter int ID_W       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             score_valid,
    output logic                             score_ready,
    input  logic signed [SCORE_W-1:0]        score_value,
    input  logic        [ID_W-1:0]           student_id,
    input  logic                             bonus_valid,
    output logic                             bonus_ready,
    input  logic signed [SCORE_W-1:0]        bonus_value,
    input  logic                             flush,
    output logic                             rec_valid,
    input  logic                             rec_ready,
    output logic signed [SCORE_W-1:0]        rec_base,
    output logic                             rec_extra,
    output logic signed [SCORE_W-1:0]        rec_bonus,
    output logic        [ID_W-1:0]           rec_id,
    output logic [$clog2(NUM_SCORES):0]      rec_count
);
    localparam int LOG_N = $clog2(NUM_SCORES);
    localparam int CNT_W = LOG_N + 1;
    localparam int SUM_W = SCORE_W - 1 + LOG_N + 1;
    localparam logic signed [SCORE_W-1:0] S_MIN = SCORE_W'(SCORE_MIN);
    localparam logic signed [SCORE_W-1:0] S_MAX = SCORE_W'(SCORE_MAX);
    localparam logic signed [SCORE_W-1:0] S_INV = SCORE_W'(INVALID_VALUE);
    acc_state_t               state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic                     bad_score_q, bad_score_d, extra_q, extra_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     collect, score_acc, bonus_acc, last, done, clr, score_ok;
    logic [SCORE_W-1:0]       nxt_bonus;
    logic                     nxt_bad;
    always_comb begin
        collect     = state_q == COLLECT;
        score_acc   = collect && score_valid && !flush;
        bonus_acc   = collect && bonus_valid && !flush;
        done        = !collect && rec_ready;
        clr         = (collect && flush) || done;
        last        = score_acc && count_q == CNT_W'(NUM_SCORES - 1);
        score_ok    = score_value >= S_MIN && score_value <= S_MAX;
        count_d     = clr ? '0 : score_acc ? count_q + 1'b1 : count_q;
        // only in-range scores contribute; the MSB is zero for them so it is dropped
        sum_d       = clr ? '0 : (score_acc && score_ok) ? sum_q + SUM_W'(score_value[SCORE_W-2:0]) : sum_q;
        bad_score_d = clr ? 1'b0 : bad_score_q | (score_acc & !score_ok);
        extra_d     = clr ? 1'b0 : extra_q | bonus_acc;
        id_d        = (score_acc && count_q == '0) ? student_id : id_q;
        state_d     = last ? HOLD : done ? COLLECT : state_q;
    end
    grade_bonus_saturator #(.SCORE_W(SCORE_W), .MAX_BONUS(MAX_BONUS)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .load_i     (bonus_acc),
        .value_i    (bonus_value),
        .nxt_bonus_o(nxt_bonus),
        .nxt_bad_o  (nxt_bad)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            sum_q       <= '0;
            bad_score_q <= 1'b0;
            extra_q     <= 1'b0;
            id_q        <= '0;
            rec_base    <= '0;
            rec_bonus   <= '0;
            rec_extra   <= 1'b0;
            rec_id      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            bad_score_q <= bad_score_d;
            extra_q     <= extra_d;
            id_q        <= id_d;
            // record is built from next-state values so a same-edge final score/bonus counts
            if (last) begin
                rec_base  <= bad_score_d ? S_INV : SCORE_W'(sum_d >> LOG_N);
                rec_bonus <= nxt_bad ? S_INV : nxt_bonus;
                rec_extra <= extra_d;
                rec_id    <= id_d;
            end
        end
    end
    assign score_ready = collect;
    assign bonus_ready = collect;
    assign rec_valid   = !collect;
    assign rec_count   = count_q;
endmodule
